dot_layer: RTL and testbench
============================

DOT_LAYER -- requirements
Module: dot_layer

Interface
REQ-001 The block SHALL have parameter ORG_H, default 49, meaning the screen x of the dot-grid left edge.
REQ-002 The block SHALL have parameter ORG_V, default 191, meaning the screen y of the dot-grid top edge.
REQ-003 The block SHALL have parameter TILE, default 30, meaning the square tile size in pixels.
REQ-004 The block SHALL have parameter COLS, default 19, meaning the number of grid columns.
REQ-005 The block SHALL have parameter ROWS, default 9, meaning the number of grid rows.
REQ-006 The block SHALL have parameter KEY, default 12'h000, meaning the transparent sprite colour.
REQ-007 The block SHALL have port clk, input, 1 bit: the pixel clock, sole clock domain.
REQ-008 The block SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-009 The block SHALL have port h_cnt, input, 10 bits: current pixel x.
REQ-010 The block SHALL have port v_cnt, input, 10 bits: current pixel y.
REQ-011 The block SHALL have port valid, input, 1 bit: visible-area flag, aligned with h_cnt/v_cnt.
REQ-012 The block SHALL have port dot_pixel_data, input, 12 bits: dot ROM output, arriving 1 cycle after h_cnt/v_cnt.
REQ-013 The block SHALL have port pac_col, input, 5 bits: Pac-Man tile column.
REQ-014 The block SHALL have port pac_row, input, 4 bits: Pac-Man tile row.
REQ-015 The block SHALL have port pac_eat, input, 1 bit: one-cycle request to eat the dot at pac_col/pac_row.
REQ-016 The block SHALL have port refill, input, 1 bit: one-cycle level-restart pulse.
REQ-017 The block SHALL have port dot_on, output, 1 bit: the current pixel shows an opaque dot.
REQ-018 The block SHALL have port dot_rgb, output, 12 bits: the dot colour, 0 when dot_on=0.
REQ-019 The block SHALL have port eat_pulse, output, 1 bit: one-cycle strobe when a dot is consumed.
REQ-020 The block SHALL have port dots_left, output, 8 bits: number of dots remaining.
REQ-021 The block SHALL have port all_clear, output, 1 bit: high while dots_left==0.

Function
REQ-022 The block SHALL hold one presence bit per tile, COLS*ROWS = 171 bits.
REQ-023 Stage 0 SHALL set in_grid = valid AND ORG_H <= h_cnt < ORG_H+COLS*TILE AND ORG_V <= v_cnt < ORG_V+ROWS*TILE.
REQ-024 Stage 0 SHALL compute col=(h_cnt-ORG_H)/TILE and row=(v_cnt-ORG_V)/TILE, with no divider wider than 10 bits; the result is don't-care when in_grid=0.
REQ-025 Stage 1 SHALL register in_grid AND present[row][col], so that it aligns with dot_pixel_data.
REQ-026 Stage 2 SHALL register dot_on = stage1_bit AND (dot_pixel_data != KEY), and dot_rgb = dot_on ? dot_pixel_data : 0.
REQ-027 dot_on/dot_rgb latency SHALL be exactly 2 clk cycles after h_cnt/v_cnt.
REQ-028 When pac_eat=1, pac_col<COLS, pac_row<ROWS and the presence bit is 1, the block SHALL clear the bit, decrement dots_left, and assert eat_pulse for exactly the next cycle.
REQ-029 When pac_eat targets an empty tile or an out-of-range tile, the block SHALL leave all state unchanged and keep eat_pulse=0.
REQ-030 A pac_eat held high for N cycles on the same tile SHALL produce exactly one eat_pulse.
REQ-031 refill=1 SHALL set all presence bits to 1 and dots_left to 171 on the next edge, with eat_pulse=0.
REQ-032 refill SHALL take priority over a simultaneous pac_eat.
REQ-033 dots_left SHALL never underflow below 0.
REQ-034 all_clear SHALL be registered and SHALL equal (dots_left==0) one cycle after dots_left changes.
REQ-035 A render read and an eat on the same tile in the same cycle SHALL render the pre-eat value.

Reset
REQ-036 While rst_n=0 at a clk edge, the block SHALL set all presence bits to 1, dots_left=171, and dot_on, dot_rgb, eat_pulse and all_clear to 0, and SHALL clear the pipeline stages.
REQ-037 Reset asserted mid-frame SHALL take effect on the next edge; the first 2 output cycles after release SHALL reflect only post-reset inputs.

Verification
REQ-038 The bench SHALL check: reset, then h=49, v=191, valid=1, ROM=12'hFF0 -> 2 cycles later dot_on=1, dot_rgb=12'hFF0.
REQ-039 The bench SHALL check: pac_col=0, pac_row=0, pac_eat=1 for 3 cycles -> a single eat_pulse, dots_left=170, and the same pixel later gives dot_on=0.
REQ-040 The bench SHALL check: h=48 or h=619 or v=461 with ROM non-key -> dot_on=0; ROM=12'h000 inside the grid -> dot_on=0.
REQ-041 The bench SHALL check: pac_col=19, pac_row=3, pac_eat=1 -> no eat_pulse and dots_left unchanged.
REQ-042 The bench SHALL check: eat all 171 tiles -> dots_left=0, all_clear=1 one cycle later, and further pac_eat leaves it at 0.
REQ-043 The bench SHALL check: refill and pac_eat in the same cycle -> dots_left=171, eat_pulse=0, all_clear=0 next cycle.

Source files
------------

// File: rtl/dot_layer.sv
// Dot overlay for a tile grid: renders remaining dots 2 cycles after h_cnt/v_cnt and tracks eaten tiles.
// Eat requests take effect on the next edge. Refill restores every dot and wins over a simultaneous eat.
module dot_layer #(
  parameter int          ORG_H = 49,
  parameter int          ORG_V = 191,
  parameter int          TILE  = 30,
  parameter int          COLS  = 19,
  parameter int          ROWS  = 9,
  parameter logic [11:0] KEY   = 12'h000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  h_cnt,
  input  logic [9:0]  v_cnt,
  input  logic        valid,
  input  logic [11:0] dot_pixel_data,
  input  logic [4:0]  pac_col,
  input  logic [3:0]  pac_row,
  input  logic        pac_eat,
  input  logic        refill,
  output logic        dot_on,
  output logic [11:0] dot_rgb,
  output logic        eat_pulse,
  output logic [7:0]  dots_left,
  output logic        all_clear
);

  localparam int         N     = COLS * ROWS;
  localparam int         IW    = $clog2(N);
  localparam logic [9:0] H0    = 10'(ORG_H);
  localparam logic [9:0] H1    = 10'(ORG_H + COLS * TILE);
  localparam logic [9:0] V0    = 10'(ORG_V);
  localparam logic [9:0] V1    = 10'(ORG_V + ROWS * TILE);
  localparam logic [9:0] T     = 10'(TILE);
  localparam logic [4:0] C_LIM = 5'(COLS);
  localparam logic [3:0] R_LIM = 4'(ROWS);

  logic [N-1:0]  present;
  logic [9:0]    dx, dy;
  logic [IW-1:0] pix_idx, eat_idx;
  logic          in_grid, pix_bit, eat_ok, dot_hit, s1_bit;

  always_comb begin
    in_grid = valid && (h_cnt >= H0) && (h_cnt < H1) && (v_cnt >= V0) && (v_cnt < V1);
    dx      = h_cnt - H0;
    dy      = v_cnt - V0;
    // Constant-divisor 10-bit divides; index is garbage outside the grid but masked by in_grid.
    pix_idx = IW'(dy / T) * IW'(COLS) + IW'(dx / T);
    pix_bit = in_grid && present[pix_idx];
    eat_idx = IW'(pac_row) * IW'(COLS) + IW'(pac_col);
    eat_ok  = pac_eat && (pac_col < C_LIM) && (pac_row < R_LIM) &&
              present[eat_idx] && (dots_left != 8'd0);
    dot_hit = s1_bit && (dot_pixel_data != KEY);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      present   <= '1;
      dots_left <= 8'(N);
      eat_pulse <= 1'b0;
      all_clear <= 1'b0;
      s1_bit    <= 1'b0;
      dot_on    <= 1'b0;
      dot_rgb   <= 12'h000;
    end else begin
      // Render path samples the presence vector before this edge's eat lands.
      s1_bit    <= pix_bit;
      dot_on    <= dot_hit;
      dot_rgb   <= dot_hit ? dot_pixel_data : 12'h000;
      all_clear <= (dots_left == 8'd0);
      if (refill) begin
        present   <= '1;
        dots_left <= 8'(N);
        eat_pulse <= 1'b0;
      end else begin
        eat_pulse <= eat_ok;
        if (eat_ok) begin
          present[eat_idx] <= 1'b0;
          dots_left        <= dots_left - 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dot_layer.sv
// Directed bench for dot_layer: rendering window/key, eating, clear detection, refill and reset.
module tb_dot_layer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  h_cnt, v_cnt;
  logic        valid;
  logic [11:0] dot_pixel_data;
  logic [4:0]  pac_col;
  logic [3:0]  pac_row;
  logic        pac_eat, refill;
  logic        dot_on;
  logic [11:0] dot_rgb;
  logic        eat_pulse;
  logic [7:0]  dots_left;
  logic        all_clear;

  int n_cmp = 0;
  int n_bad = 0;
  int pulses;

  dot_layer dut (
    .clk(clk), .rst_n(rst_n), .h_cnt(h_cnt), .v_cnt(v_cnt), .valid(valid),
    .dot_pixel_data(dot_pixel_data), .pac_col(pac_col), .pac_row(pac_row),
    .pac_eat(pac_eat), .refill(refill), .dot_on(dot_on), .dot_rgb(dot_rgb),
    .eat_pulse(eat_pulse), .dots_left(dots_left), .all_clear(all_clear)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a pixel, supply the ROM word one cycle later, check outputs two cycles after the pixel.
  task automatic render(input string tag, input logic [9:0] h, input logic [9:0] v,
                        input logic vl, input logic [11:0] rom,
                        input logic exp_on, input logic [11:0] exp_rgb);
    h_cnt = h; v_cnt = v; valid = vl; dot_pixel_data = 12'hABC;
    tick();
    valid = 1'b0; dot_pixel_data = rom;
    tick();
    chk({tag, "_on"}, 32'(dot_on), 32'(exp_on));
    chk({tag, "_rgb"}, 32'(dot_rgb), 32'(exp_rgb));
    dot_pixel_data = 12'h000;
  endtask

  initial begin
    rst_n = 1'b0; h_cnt = '0; v_cnt = '0; valid = 1'b0; dot_pixel_data = '0;
    pac_col = '0; pac_row = '0; pac_eat = 1'b0; refill = 1'b0;
    tick(); tick();
    chk("rst_dot_on", 32'(dot_on), 32'd0);
    chk("rst_dot_rgb", 32'(dot_rgb), 32'd0);
    chk("rst_eat_pulse", 32'(eat_pulse), 32'd0);
    chk("rst_dots_left", 32'(dots_left), 32'd171);
    chk("rst_all_clear", 32'(all_clear), 32'd0);
    rst_n = 1'b1;

    // Mid-frame reset flushes an in-flight visible pixel.
    h_cnt = 10'd49; v_cnt = 10'd191; valid = 1'b1; dot_pixel_data = 12'hFF0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; valid = 1'b0;
    tick();
    chk("midrst_dot_on", 32'(dot_on), 32'd0);
    tick();
    chk("midrst_dot_on2", 32'(dot_on), 32'd0);

    render("first_tile", 10'd49, 10'd191, 1'b1, 12'hFF0, 1'b1, 12'hFF0);
    render("last_tile", 10'd618, 10'd460, 1'b1, 12'h0F0, 1'b1, 12'h0F0);
    render("left_edge", 10'd48, 10'd200, 1'b1, 12'hFFF, 1'b0, 12'h000);
    render("right_edge", 10'd619, 10'd200, 1'b1, 12'hFFF, 1'b0, 12'h000);
    render("bottom_edge", 10'd100, 10'd461, 1'b1, 12'hFFF, 1'b0, 12'h000);
    render("key_colour", 10'd100, 10'd200, 1'b1, 12'h000, 1'b0, 12'h000);
    render("not_valid", 10'd100, 10'd200, 1'b0, 12'hFFF, 1'b0, 12'h000);

    // Eat held for 3 cycles on tile (0,0): a single pulse.
    pulses = 0;
    pac_col = 5'd0; pac_row = 4'd0; pac_eat = 1'b1;
    tick();
    chk("eat_pulse_first", 32'(eat_pulse), 32'd1);
    chk("eat_dots_left", 32'(dots_left), 32'd170);
    pulses += int'(eat_pulse);
    tick(); pulses += int'(eat_pulse);
    tick(); pulses += int'(eat_pulse);
    pac_eat = 1'b0;
    tick(); pulses += int'(eat_pulse);
    chk("held_eat_pulses", 32'(pulses), 32'd1);
    chk("held_eat_left", 32'(dots_left), 32'd170);
    render("eaten_tile", 10'd49, 10'd191, 1'b1, 12'hFF0, 1'b0, 12'h000);
    render("neighbour_tile", 10'd79, 10'd191, 1'b1, 12'h00F, 1'b1, 12'h00F);

    // Render and eat of tile (2,0) in the same cycle: pixel shows the pre-eat dot.
    h_cnt = 10'd109; v_cnt = 10'd191; valid = 1'b1;
    pac_col = 5'd2; pac_row = 4'd0; pac_eat = 1'b1;
    tick();
    pac_eat = 1'b0; valid = 1'b0; dot_pixel_data = 12'h123;
    tick();
    chk("same_cycle_render", 32'(dot_on), 32'd1);
    chk("same_cycle_left", 32'(dots_left), 32'd169);

    // Out-of-range column.
    pac_col = 5'd19; pac_row = 4'd3; pac_eat = 1'b1;
    tick();
    chk("oor_eat_pulse", 32'(eat_pulse), 32'd0);
    pac_eat = 1'b0;
    tick();
    chk("oor_dots_left", 32'(dots_left), 32'd169);

    // Eat every remaining tile.
    pulses = 0;
    for (int r = 0; r < 9; r++) begin
      for (int c = 0; c < 19; c++) begin
        pac_col = 5'(c); pac_row = 4'(r); pac_eat = 1'b1;
        tick();
        pulses += int'(eat_pulse);
      end
    end
    pac_eat = 1'b0;
    chk("clear_pulses", 32'(pulses), 32'd169);
    chk("clear_dots_left", 32'(dots_left), 32'd0);
    chk("clear_not_yet", 32'(all_clear), 32'd0);
    tick();
    chk("all_clear", 32'(all_clear), 32'd1);
    pac_col = 5'd5; pac_row = 4'd5; pac_eat = 1'b1;
    tick();
    pac_eat = 1'b0;
    chk("empty_eat_pulse", 32'(eat_pulse), 32'd0);
    chk("empty_dots_left", 32'(dots_left), 32'd0);

    // Refill with a simultaneous eat.
    refill = 1'b1; pac_col = 5'd1; pac_row = 4'd0; pac_eat = 1'b1;
    tick();
    refill = 1'b0; pac_eat = 1'b0;
    chk("refill_dots_left", 32'(dots_left), 32'd171);
    chk("refill_eat_pulse", 32'(eat_pulse), 32'd0);
    tick();
    chk("refill_all_clear", 32'(all_clear), 32'd0);
    chk("refill_dots_hold", 32'(dots_left), 32'd171);
    render("refilled_tile", 10'd79, 10'd191, 1'b1, 12'hF0F, 1'b1, 12'hF0F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
